// File: rtl/chip8_mem_pkg.sv
// Shared definitions for the CHIP-8 main-memory controller.
//   - Default geometry (address width, word width, burst length, opcode size)
//   - Burst and fetch FSM state encodings
//   - Byte-lane and counter-width helpers used by the controller and RAM
package chip8_mem_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 8;
  localparam int MAX_BURST_DEF   = 16;
  localparam int FETCH_BYTES_DEF = 2;
  localparam int OPCODE_W_DEF    = FETCH_BYTES_DEF * DATA_W_DEF;

  typedef enum logic [1:0] {
    B_IDLE,
    B_WRITE,
    B_READ,
    B_DONE
  } burst_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_READ,
    F_VALID
  } fetch_state_t;

  // Lowest bit of byte lane i in a flat buffer of w-bit words.
  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip8_ram.sv
// Dual-port synchronous RAM for the CHIP-8 address space.
//   clk      in   clock
//   a_we     in   burst port write enable
//   a_addr   in   burst port address (read and write)
//   a_wdata  in   burst port write data
//   a_rdata  out  burst port read data, one cycle after a_addr
//   b_addr   in   fetch port address (read only)
//   b_rdata  out  fetch port read data, one cycle after b_addr
// Both read ports return the contents from before a same-edge write.
module chip8_ram
  import chip8_mem_pkg::*;
#(
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter int    DATA_W    = DATA_W_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Power-up image: all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_reg[i] = '0;
  end

  // Non-blocking update gives read-before-write on both ports.
  always_ff @(posedge clk) begin
    if (a_we) mem_reg[a_addr] <= a_wdata;
    a_rdata <= mem_reg[a_addr];
    b_rdata <= mem_reg[b_addr];
  end

endmodule

// File: rtl/chip8_burst_mem.sv
// CHIP-8 main-memory controller: burst port plus independent opcode fetch.
//   clk, reset              clock; synchronous active-high reset
//   req_valid/req_ready     burst request handshake
//   req_write               1 = wr_buf -> memory, 0 = memory -> rd_buf
//   req_addr, req_count     first byte address, burst length minus one
//   wr_buf, rd_buf          flat byte buffers, byte i at [i*DATA_W +: DATA_W]
//   done                    one-cycle pulse when the burst completes
//   fetch_req, fetch_pc     start an opcode fetch
//   fetch_busy              fetch in progress, new requests ignored
//   opcode, opcode_valid    big-endian opcode and its one-cycle strobe
module chip8_burst_mem
  import chip8_mem_pkg::*;
#(
  parameter int    ADDR_W      = ADDR_W_DEF,
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    MAX_BURST   = MAX_BURST_DEF,
  parameter int    FETCH_BYTES = FETCH_BYTES_DEF,
  parameter string INIT_FILE   = "",
  localparam int   CNT_W       = cnt_width(MAX_BURST)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [CNT_W-1:0]              req_count,
  input  logic [MAX_BURST*DATA_W-1:0]   wr_buf,
  output logic [MAX_BURST*DATA_W-1:0]   rd_buf,
  output logic                          done,
  input  logic                          fetch_req,
  input  logic [ADDR_W-1:0]             fetch_pc,
  output logic                          fetch_busy,
  output logic [FETCH_BYTES*DATA_W-1:0] opcode,
  output logic                          opcode_valid
);

  localparam int BUF_W = MAX_BURST * DATA_W;
  localparam int OP_W  = FETCH_BYTES * DATA_W;
  // Beat counter runs to count+2 (read drain), hence two spare bits.
  localparam int BC_W  = CNT_W + 2;
  localparam int FC_W  = cnt_width(FETCH_BYTES + 1);

  // ---------------- Burst side ----------------
  burst_state_t      b_state_reg, b_state_next;
  logic [BC_W-1:0]   bcnt_reg, bcnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [BUF_W-1:0]  wbuf_reg;
  logic [BUF_W-1:0]  rd_buf_reg;
  logic              rd_pend_reg;
  logic [CNT_W-1:0]  rd_idx_reg;

  logic              accept;
  logic              in_range;
  logic [CNT_W-1:0]  beat;
  logic              ram_a_we;
  logic [ADDR_W-1:0] ram_a_addr;
  logic [DATA_W-1:0] ram_a_wdata;
  logic [DATA_W-1:0] ram_a_rdata;
  logic [DATA_W-1:0] wbuf_bytes [MAX_BURST];

  generate
    for (genvar gi = 0; gi < MAX_BURST; gi++) begin : g_wbuf_lane
      assign wbuf_bytes[gi] = wbuf_reg[lane_lo(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  assign req_ready   = (b_state_reg == B_IDLE);
  assign done        = (b_state_reg == B_DONE);
  assign accept      = req_valid && req_ready;
  assign beat        = bcnt_reg[CNT_W-1:0];
  // Beats past count are drain cycles: no memory access is issued.
  assign in_range    = (bcnt_reg <= BC_W'(count_reg));
  assign ram_a_we    = (b_state_reg == B_WRITE) && in_range;
  assign ram_a_addr  = addr_reg + ADDR_W'(beat);
  assign ram_a_wdata = wbuf_bytes[beat];
  assign rd_buf      = rd_buf_reg;

  always_comb begin
    b_state_next = b_state_reg;
    bcnt_next    = bcnt_reg;
    case (b_state_reg)
      B_IDLE: begin
        if (accept) begin
          b_state_next = req_write ? B_WRITE : B_READ;
          bcnt_next    = '0;
        end
      end
      B_WRITE: begin
        bcnt_next = bcnt_reg + BC_W'(1);
        // One idle beat after the last write places done at count+2.
        if (bcnt_reg == BC_W'(count_reg) + BC_W'(1)) b_state_next = B_DONE;
      end
      B_READ: begin
        bcnt_next = bcnt_reg + BC_W'(1);
        // Two beats after the last address: RAM latency plus capture.
        if (bcnt_reg == BC_W'(count_reg) + BC_W'(2)) b_state_next = B_DONE;
      end
      B_DONE:  b_state_next = B_IDLE;
      default: b_state_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_state_reg <= B_IDLE;
      bcnt_reg    <= '0;
      addr_reg    <= '0;
      count_reg   <= '0;
      wbuf_reg    <= '0;
      rd_pend_reg <= 1'b0;
      rd_idx_reg  <= '0;
    end else begin
      b_state_reg <= b_state_next;
      bcnt_reg    <= bcnt_next;
      if (accept) begin
        addr_reg  <= req_addr;
        count_reg <= req_count;
        wbuf_reg  <= wr_buf;
      end
      // Tracks the RAM's one-cycle read latency for the capture below.
      rd_pend_reg <= (b_state_reg == B_READ) && in_range;
      rd_idx_reg  <= beat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_buf_reg <= '0;
    end else begin
      for (int i = 0; i < MAX_BURST; i++) begin
        if (accept && !req_write && (i > int'(req_count)))
          rd_buf_reg[lane_lo(i, DATA_W) +: DATA_W] <= '0;
        else if (rd_pend_reg && (int'(rd_idx_reg) == i))
          rd_buf_reg[lane_lo(i, DATA_W) +: DATA_W] <= ram_a_rdata;
      end
    end
  end

  // ---------------- Fetch side ----------------
  fetch_state_t      f_state_reg, f_state_next;
  logic [FC_W-1:0]   fcnt_reg;
  logic [ADDR_W-1:0] fpc_reg;
  logic [OP_W-1:0]   fshift_reg;
  logic [OP_W-1:0]   opcode_reg;
  logic              f_accept;
  logic              f_last;
  logic [ADDR_W-1:0] ram_b_addr;
  logic [DATA_W-1:0] ram_b_rdata;

  assign fetch_busy   = (f_state_reg != F_IDLE);
  assign opcode_valid = (f_state_reg == F_VALID);
  assign opcode       = opcode_reg;
  assign f_accept     = fetch_req && (f_state_reg == F_IDLE);
  assign f_last       = (fcnt_reg == FC_W'(FETCH_BYTES));
  assign ram_b_addr   = fpc_reg + ADDR_W'(fcnt_reg);

  always_comb begin
    f_state_next = f_state_reg;
    case (f_state_reg)
      F_IDLE:  if (f_accept) f_state_next = F_READ;
      F_READ:  if (f_last)   f_state_next = F_VALID;
      F_VALID: f_state_next = F_IDLE;
      default: f_state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_state_reg <= F_IDLE;
      fcnt_reg    <= '0;
      fpc_reg     <= '0;
      fshift_reg  <= '0;
      opcode_reg  <= '0;
    end else begin
      f_state_reg <= f_state_next;
      if (f_accept) begin
        fpc_reg  <= fetch_pc;
        fcnt_reg <= '0;
      end else if (f_state_reg == F_READ) begin
        fcnt_reg <= fcnt_reg + FC_W'(1);
        // Byte k arrives while fcnt = k+1; earlier bytes shift toward MSBs.
        if (fcnt_reg != '0) fshift_reg <= OP_W'({fshift_reg, ram_b_rdata});
        if (f_last) opcode_reg <= OP_W'({fshift_reg, ram_b_rdata});
      end
    end
  end

  chip8_ram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .a_we   (ram_a_we),
    .a_addr (ram_a_addr),
    .a_wdata(ram_a_wdata),
    .a_rdata(ram_a_rdata),
    .b_addr (ram_b_addr),
    .b_rdata(ram_b_rdata)
  );

endmodule
